mult_booth_n: RTL and testbench

Parametrised sequential Booth (radix-2) multiplier. It is the N-bit successor of the 4-bit add/shift multiplier and adds a signed/unsigned mode, a busy flag and a held, registered product. It sits beside the ALU datapath and is driven by a start/fin handshake from the control unit. One add/subtract plus arithmetic shift is done per clock.

---
 rtl/mult_pkg.sv | 8 +
 rtl/uc_booth.sv | 53 +++++
 rtl/mult_booth_n.sv | 44 ++++
 tb/tb_mult_booth_n.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state, Booth op codes and counter width for the Booth multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} op_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction
endpackage

// File: rtl/uc_booth.sv
// uc_booth: control FSM and iteration counter steering the Booth datapath
module uc_booth
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  output logic load,
  output logic add,
  output logic sub,
  output logic shift,
  output logic store,
  output logic fin,
  output logic ocupado
);
  localparam int CW = cnt_w(N);
  state_t state;
  logic [CW-1:0] cnt;
  op_t op;
  assign op = {q0, qm1} == 2'b01 ? OP_ADD : {q0, qm1} == 2'b10 ? OP_SUB : OP_NOP;
  assign load = state == IDLE && start;
  assign shift = state == RUN;
  assign add = shift && op == OP_ADD;
  assign sub = shift && op == OP_SUB;
  assign store = state == DONE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      fin <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      fin <= store;
      if (load) begin
        state <= RUN;
        cnt <= CW'(N + 1);
        ocupado <= 1'b1;
      end else if (shift) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= DONE;
          ocupado <= 1'b0;
        end
      end else if (store) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: rtl/mult_booth_n.sv
// mult_booth_n: sequential radix-2 Booth multiplier, signed or unsigned N-bit operands
module mult_booth_n
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           signo,
  input  logic [N-1:0]   multiplicador,
  input  logic [N-1:0]   multiplicando,
  output logic [2*N-1:0] producto,
  output logic           ocupado,
  output logic           fin
);
  logic [N:0] a, m, q, sum;
  logic qm1, load, add, sub, shift, store;
  uc_booth #(.N(N)) uc (
    .clk(clk), .reset_n(reset_n), .start(start), .q0(q[0]), .qm1(qm1),
    .load(load), .add(add), .sub(sub), .shift(shift), .store(store),
    .fin(fin), .ocupado(ocupado)
  );
  assign sum = add ? a + m : sub ? a - m : a;
  // One extra operand bit lets unsigned inputs run as ordinary signed Booth
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a <= '0;
      m <= '0;
      q <= '0;
      qm1 <= 1'b0;
      producto <= '0;
    end else if (load) begin
      a <= '0;
      qm1 <= 1'b0;
      m <= {signo & multiplicando[N-1], multiplicando};
      q <= {signo & multiplicador[N-1], multiplicador};
    end else if (shift) begin
      {a, q, qm1} <= {sum[N], sum, q};
    end else if (store) begin
      producto <= {a[N-2:0], q};
    end
  end
endmodule

// File: tb/tb_mult_booth_n.sv
// tb_mult_booth_n: N=4/8/16 Booth multipliers run in lockstep against an arithmetic model
module tb_mult_booth_n;
  localparam int W [3] = '{4, 8, 16};
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, signo = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic [7:0] p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic o4, o8, o16, f4, f8, f16;
  logic [2:0] fv, ov;
  int errors = 0, checks = 0;
  int lat [3], nf [3];
  int busy8;
  logic [31:0] prod [3];

  mult_booth_n #(.N(4)) u4 (.clk(clk), .reset_n(reset_n), .start(start), .signo(signo),
    .multiplicador(x[3:0]), .multiplicando(y[3:0]), .producto(p4), .ocupado(o4), .fin(f4));
  mult_booth_n #(.N(8)) u8 (.clk(clk), .reset_n(reset_n), .start(start), .signo(signo),
    .multiplicador(x[7:0]), .multiplicando(y[7:0]), .producto(p8), .ocupado(o8), .fin(f8));
  mult_booth_n #(.N(16)) u16 (.clk(clk), .reset_n(reset_n), .start(start), .signo(signo),
    .multiplicador(x), .multiplicando(y), .producto(p16), .ocupado(o16), .fin(f16));

  always #5 clk = ~clk;
  assign fv = {f16, f8, f4};
  assign ov = {o16, o8, o4};

  function automatic logic [31:0] model(input int n, input bit s, input logic [15:0] a, input logic [15:0] b);
    longint va, vb, full;
    va = longint'(a) & ((64'sd1 <<< n) - 1);
    vb = longint'(b) & ((64'sd1 <<< n) - 1);
    if (s && va[n-1]) va = va - (64'sd1 <<< n);
    if (s && vb[n-1]) vb = vb - (64'sd1 <<< n);
    full = (va * vb) & ((64'sd1 <<< (2 * n)) - 1);
    return full[31:0];
  endfunction

  task automatic run_op(input bit s, input logic [15:0] a, input logic [15:0] b, input int poke, input int rst_c);
    signo = s; x = a; y = b; start = 1'b1;
    busy8 = 0;
    for (int i = 0; i < 3; i++) begin lat[i] = -1; nf[i] = 0; end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = (c == poke);
      if (c == poke) begin x = 16'h0909; y = 16'h0909; end
      reset_n = (c != rst_c);
      busy8 += int'(o8);
      for (int i = 0; i < 3; i++)
        if (fv[i]) begin nf[i]++; if (lat[i] < 0) lat[i] = c; end
    end
    prod[0] = 32'(p4); prod[1] = 32'(p8); prod[2] = p16;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({fv[i], ov[i]} !== 2'b00) begin errors++; $display("FAIL reset_flags w=%0d fin/ocupado=%b want 00", W[i], {fv[i], ov[i]}); end
    end
    checks++;
    if ({p4, p8, p16} !== 56'd0) begin errors++; $display("FAIL reset_prod got %h/%h/%h want 0", p4, p8, p16); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed_basic();
    run_op(1'b1, 16'h00FD, 16'h0005, -1, -1);
    checks++;
    if (prod[1] !== 32'h0000FFF1) begin errors++; $display("FAIL basic_prod8 got %h want FFF1", prod[1]); end
    checks++;
    if (busy8 != 9) begin errors++; $display("FAIL basic_busy8 got %0d want 9", busy8); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lat[i] != W[i] + 2 || nf[i] != 1) begin errors++; $display("FAIL basic_fin w=%0d lat=%0d pulses=%0d want lat=%0d pulses=1", W[i], lat[i], nf[i], W[i] + 2); end
    end
  endtask

  task automatic test_corners();
    logic [48:0] tbl [6];
    logic [48:0] row;
    tbl[0] = {1'b0, 16'h00FF, 16'h00FF, 16'hFE01};
    tbl[1] = {1'b1, 16'h00FF, 16'h00FF, 16'h0001};
    tbl[2] = {1'b1, 16'h0080, 16'h0080, 16'h4000};
    tbl[3] = {1'b1, 16'h007F, 16'h0080, 16'hC080};
    tbl[4] = {1'b1, 16'h8008, 16'h8008, 16'h0040};
    tbl[5] = {1'b0, 16'hFFFF, 16'hFFFF, 16'hFE01};
    for (int t = 0; t < 6; t++) begin
      row = tbl[t];
      run_op(row[48], row[47:32], row[31:16], -1, -1);
      checks++;
      if (prod[1][15:0] !== row[15:0]) begin errors++; $display("FAIL corner%0d_prod8 got %h want %h", t, prod[1][15:0], row[15:0]); end
      for (int i = 0; i < 3; i += 2) begin
        checks++;
        if (prod[i] !== model(W[i], row[48], row[47:32], row[31:16])) begin
          errors++; $display("FAIL corner%0d_prod w=%0d got %h want %h", t, W[i], prod[i], model(W[i], row[48], row[47:32], row[31:16]));
        end
      end
    end
  endtask

  task automatic test_handshake();
    run_op(1'b0, 16'h0003, 16'h0004, 3, -1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (prod[i] !== 32'd12 || nf[i] != 1) begin errors++; $display("FAIL handshake w=%0d prod=%h pulses=%0d want 0000000c pulses=1", W[i], prod[i], nf[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    run_op(1'b1, 16'h007F, 16'h0055, -1, 4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (prod[i] !== 32'd0 || nf[i] != 0) begin errors++; $display("FAIL midreset w=%0d prod=%h pulses=%0d want 0 pulses=0", W[i], prod[i], nf[i]); end
    end
    run_op(1'b0, 16'h0002, 16'h0003, -1, -1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (prod[i] !== 32'd6) begin errors++; $display("FAIL after_reset w=%0d got %h want 6", W[i], prod[i]); end
    end
  endtask

  task automatic test_random();
    bit s;
    logic [15:0] a, b;
    for (int t = 0; t < 20; t++) begin
      s = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      run_op(s, a, b, -1, -1);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (prod[i] !== model(W[i], s, a, b) || lat[i] != W[i] + 2) begin
          errors++; $display("FAIL random w=%0d s=%0d %h*%h got %h lat=%0d want %h lat=%0d", W[i], s, a, b, prod[i], lat[i], model(W[i], s, a, b), W[i] + 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int last [3], cnt [3];
    signo = 1'b1; x = 16'hA5C3; y = 16'h3C96; start = 1'b1;
    for (int i = 0; i < 3; i++) begin last[i] = -1; cnt[i] = 0; end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (fv[i]) begin
          cnt[i]++;
          if (last[i] >= 0) begin
            checks++;
            if (c - last[i] != W[i] + 3) begin errors++; $display("FAIL b2b_gap w=%0d got %0d want %0d", W[i], c - last[i], W[i] + 3); end
          end
          last[i] = c;
        end
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    prod[0] = 32'(p4); prod[1] = 32'(p8); prod[2] = p16;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] != (99 - (W[i] + 2)) / (W[i] + 3) + 1 || prod[i] !== model(W[i], 1'b1, 16'hA5C3, 16'h3C96)) begin
        errors++; $display("FAIL b2b w=%0d pulses=%0d prod=%h want pulses=%0d prod=%h", W[i], cnt[i], prod[i], (99 - (W[i] + 2)) / (W[i] + 3) + 1, model(W[i], 1'b1, 16'hA5C3, 16'h3C96));
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_corners();
    test_handshake();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
